// File: rtl/fib_seq_monitor.sv
// Fibonacci-style sum stream checker: verifies each beat equals the sum of the two
// previous beats (with carry), tracks error/overflow statistics and keeps a short history.
module fib_seq_monitor #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_carry,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              error,
    output logic              locked,
    output logic [7:0]        err_count,
    output logic [7:0]        ovf_count,
    output logic [7:0]        seq_len,
    output logic              wrapped
);

    typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] prev2_q, prev2_d, prev1_q, prev1_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              error_q, error_d, locked_q, locked_d, wrapped_q, wrapped_d;
    logic [7:0]        err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d, seq_len_q, seq_len_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W:0]   exp_sum;
    logic              match;

    assign exp_sum = {1'b0, prev2_q} + {1'b0, prev1_q};
    assign match   = (exp_sum[DATA_W-1:0] == in_data) && (exp_sum[DATA_W] == in_carry);

    always_comb begin
        state_d   = state_q;
        prev2_d   = prev2_q;
        prev1_d   = prev1_q;
        wr_ptr_d  = wr_ptr_q;
        error_d   = 1'b0;
        locked_d  = locked_q;
        wrapped_d = wrapped_q;
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        seq_len_d = seq_len_q;
        if (in_valid) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            seq_len_d = sat_inc(seq_len_q);
            if (wr_ptr_q == AW'(DEPTH - 1))
                wrapped_d = 1'b1;
            case (state_q)
                IDLE: begin
                    prev2_d = in_data;
                    state_d = SEED;
                end
                SEED: begin
                    prev1_d = in_data;
                    state_d = RUN;
                end
                RUN: begin
                    // Shift in the observed value either way so a glitch resyncs the checker.
                    prev2_d = prev1_q;
                    prev1_d = in_data;
                    if (exp_sum[DATA_W])
                        ovf_cnt_d = sat_inc(ovf_cnt_q);
                    if (match) begin
                        locked_d = 1'b1;
                    end else begin
                        locked_d  = 1'b0;
                        error_d   = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prev2_q   <= '0;
            prev1_q   <= '0;
            wr_ptr_q  <= '0;
            error_q   <= 1'b0;
            locked_q  <= 1'b0;
            wrapped_q <= 1'b0;
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
            seq_len_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            prev2_q   <= prev2_d;
            prev1_q   <= prev1_d;
            wr_ptr_q  <= wr_ptr_d;
            error_q   <= error_d;
            locked_q  <= locked_d;
            wrapped_q <= wrapped_d;
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
            seq_len_q <= seq_len_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    // History storage is never reset; only accepted beats write it.
    always_ff @(posedge clk) begin
        if (in_valid && !rst)
            mem[wr_ptr_q] <= in_data;
    end

    assign rd_data   = rd_data_q;
    assign error     = error_q;
    assign locked    = locked_q;
    assign err_count = err_cnt_q;
    assign ovf_count = ovf_cnt_q;
    assign seq_len   = seq_len_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_fib_seq_monitor.sv
// Randomized and directed bench for fib_seq_monitor against a behavioural model
// of the sum-sequence rules and the history buffer.
module tb_fib_seq_monitor;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_carry;
    logic [7:0] in_data, rd_data, err_count, ovf_count, seq_len;
    logic [3:0] rd_addr;
    logic       error, locked, wrapped;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_beats;
    int m_p2, m_p1, m_wp, m_ec, m_oc, m_sl, m_rd;
    bit m_err, m_lock, m_wrap, m_rd_known;
    int hist [DEPTH];
    bit hvld [DEPTH];

    fib_seq_monitor #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_carry(in_carry), .rd_addr(rd_addr), .rd_data(rd_data),
        .error(error), .locked(locked), .err_count(err_count),
        .ovf_count(ovf_count), .seq_len(seq_len), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_edge(input bit r, input bit v, input int d, input bit c, input int a);
        int s;
        if (r) begin
            m_beats = 0; m_p1 = 0; m_p2 = 0; m_wp = 0;
            m_err = 0; m_lock = 0; m_ec = 0; m_oc = 0; m_sl = 0; m_wrap = 0;
            m_rd = 0; m_rd_known = 1;
            return;
        end
        m_rd_known = hvld[a];
        m_rd = hist[a];
        m_err = 0;
        if (v) begin
            if (m_beats == 0) m_p2 = d;
            else if (m_beats == 1) m_p1 = d;
            else begin
                s = m_p2 + m_p1;
                if (s >= 256) m_oc = sat(m_oc + 1);
                if ((s % 256) == d && (s / 256) == int'(c)) m_lock = 1;
                else begin
                    m_lock = 0; m_err = 1; m_ec = sat(m_ec + 1);
                end
                m_p2 = m_p1;
                m_p1 = d;
            end
            m_beats++;
            hist[m_wp] = d;
            hvld[m_wp] = 1;
            if (m_wp == DEPTH - 1) m_wrap = 1;
            m_wp = (m_wp + 1) % DEPTH;
            m_sl = sat(m_sl + 1);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int d, input bit c, input int a);
        @(negedge clk);
        rst = r; in_valid = v; in_data = 8'(d); in_carry = c; rd_addr = 4'(a);
        @(posedge clk);
        model_edge(r, v, d, c, a);
        #1;
        check("error", error, m_err);
        check("locked", locked, m_lock);
        check("err_count", err_count, m_ec);
        check("ovf_count", ovf_count, m_oc);
        check("seq_len", seq_len, m_sl);
        check("wrapped", wrapped, m_wrap);
        if (m_rd_known) check("rd_data", rd_data, m_rd);
    endtask

    task automatic beat(input int d, input bit c);
        cycle(0, 1, d, c, $urandom_range(0, DEPTH - 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, $urandom_range(0, 255), 0, $urandom_range(0, DEPTH - 1));
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0);
    endtask

    initial begin
        int fib [15];
        int d;
        bit c;
        rst = 1; in_valid = 0; in_data = 0; in_carry = 0; rd_addr = 0;
        for (int i = 0; i < DEPTH; i++) begin hist[i] = 0; hvld[i] = 0; end

        // Reset state and short sequence
        do_reset();
        check("rst_seq_len", seq_len, 0);
        check("rst_rd_data", rd_data, 0);
        beat(1, 0); beat(1, 0); beat(2, 0);
        check("s1_locked_b3", locked, 1);
        beat(3, 0); beat(5, 0);
        check("s1_err_count", err_count, 0);
        check("s1_seq_len", seq_len, 5);

        // Full 8-bit sequence running into overflow
        do_reset();
        fib[0] = 1; fib[1] = 1;
        for (int i = 2; i < 13; i++) fib[i] = fib[i-1] + fib[i-2];
        for (int i = 0; i < 13; i++) beat(fib[i], 0);
        beat(121, 1); beat(98, 1);
        check("s2_err_count", err_count, 0);
        check("s2_ovf_count", ovf_count, 2);
        check("s2_locked", locked, 1);

        // Mismatch then resync
        do_reset();
        beat(1, 0); beat(1, 0); beat(2, 0); beat(4, 0);
        check("s3_error", error, 1);
        check("s3_err_count", err_count, 1);
        check("s3_locked", locked, 0);
        beat(6, 0);
        check("s3_locked_resync", locked, 1);
        check("s3_err_hold", err_count, 1);
        check("s3_error_clr", error, 0);

        // Write-pointer wrap and history readback
        do_reset();
        for (int i = 1; i <= 17; i++) beat(i, 0);
        check("s4_wrapped", wrapped, 1);
        check("s4_seq_len", seq_len, 17);
        cycle(0, 0, 0, 0, 0);
        check("s4_rd0", rd_data, 17);
        cycle(0, 0, 0, 0, 1);
        check("s4_rd1", rd_data, 2);

        // Reset mid-stream with a valid beat present
        do_reset();
        beat(3, 0); beat(4, 0); beat(9, 0);
        cycle(1, 1, 99, 1, 3);
        check("s5_rst_err_count", err_count, 0);
        check("s5_rst_seq_len", seq_len, 0);
        check("s5_rst_error", error, 0);
        beat(5, 0); beat(5, 0);
        check("s5_seed_error", error, 0);
        beat(10, 0);
        check("s5_locked", locked, 1);

        // Idle gaps between beats, then saturation of the counters
        do_reset();
        foreach (fib[i]) fib[i] = 0;
        fib[0] = 1; fib[1] = 1; fib[2] = 2; fib[3] = 4; fib[4] = 6;
        for (int i = 0; i < 5; i++) begin
            beat(fib[i], 0);
            idle($urandom_range(1, 3));
        end
        check("s6_err_count", err_count, 1);
        check("s6_locked", locked, 1);
        check("s6_seq_len", seq_len, 5);
        for (int i = 0; i < 300; i++) beat(0, 1);
        check("s6_err_sat", err_count, 255);
        check("s6_len_sat", seq_len, 255);

        // Random traffic: mostly well-formed continuations with corruption and resets
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                cycle(1, $urandom_range(0, 1), $urandom_range(0, 255), 0, $urandom_range(0, DEPTH - 1));
            end else begin
                d = (m_p2 + m_p1) % 256;
                c = ((m_p2 + m_p1) >= 256);
                if (m_beats < 2 || $urandom_range(0, 3) == 0) begin
                    d = $urandom_range(0, 255);
                    c = $urandom_range(0, 1);
                end
                cycle(0, $urandom_range(0, 1), d, c, $urandom_range(0, DEPTH - 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fib_seq_monitor.md
FIB_SEQ_MONITOR -- requirements
Module: fib_seq_monitor

Interface
REQ-001 Parameter: DATA_W, 8, width of the monitored sum value.
REQ-002 Parameter: DEPTH, 16, entries in the history buffer (power of two).
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  beat qualifier; in_data and in_carry sampled only when high.
REQ-006 Port: in_data  input  DATA_W  sum value from the upstream adder stage.
REQ-007 Port: in_carry  input  1  carry-out accompanying in_data.
REQ-008 Port: rd_addr  input  log2(DEPTH)  history buffer read address.
REQ-009 Port: rd_data  output  DATA_W  registered history read data.
REQ-010 Port: error  output  1  one-cycle pulse on a failed check.
REQ-011 Port: locked  output  1  last check passed.
REQ-012 Port: err_count  output  8  failed checks, saturating.
REQ-013 Port: ovf_count  output  8  accepted RUN beats whose expected sum overflowed, saturating.
REQ-014 Port: seq_len  output  8  accepted beats since reset, saturating.
REQ-015 Port: wrapped  output  1  sticky; history write pointer has wrapped.

Function
REQ-016 Beat accepted = in_valid high on a posedge with rst low; no state changes without an accepted beat.
REQ-017 FSM states IDLE, SEED, RUN; IDLE after reset.
REQ-018 IDLE + accepted beat: prev2 <= in_data, go to SEED, no check.
REQ-019 SEED + accepted beat: prev1 <= in_data, go to RUN, no check.
REQ-020 RUN + accepted beat: expected = prev2 + prev1 as DATA_W+1-bit sum; low DATA_W bits compared with in_data, MSB compared with in_carry.
REQ-021 RUN match: locked <= 1; prev2 <= prev1; prev1 <= in_data.
REQ-022 RUN mismatch (data or carry): error pulses high for exactly the next cycle, err_count +1 (holds at 255), locked <= 0, prev2 <= prev1, prev1 <= in_data (resync to observed stream), stays in RUN.
REQ-023 RUN beat with expected MSB = 1: ovf_count +1 (holds at 255), regardless of match.
REQ-024 Every accepted beat in any state: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr+1 mod DEPTH, seq_len +1 (holds at 255).
REQ-025 Write at wr_ptr = DEPTH-1 sets wrapped; wrapped cleared only by reset.
REQ-026 rd_data <= mem[rd_addr] each cycle, 1-cycle latency; same-cycle write and read of one address returns old contents.
REQ-027 All status outputs registered; reflect an accepted beat in the cycle after it.
REQ-028 error low in every cycle not immediately following a mismatching beat.

Reset
REQ-029 rst dominates in_valid in the same cycle; beat discarded.
REQ-030 On rst: state IDLE, prev1 = prev2 = 0, wr_ptr = 0, error = 0, locked = 0, err_count = 0, ovf_count = 0, seq_len = 0, wrapped = 0, rd_data = 0.
REQ-031 History memory contents not cleared by reset; rd_data of unwritten entries is don't-care after the first post-reset read.

Verification
REQ-032 Reset, beats 1,1,2,3,5 carry 0 -> err_count 0, locked 1 after 3rd beat, seq_len 5, error never high.
REQ-033 Full sequence 1,1,2,...,144,233 then 121 carry 1, 98 carry 1 -> err_count 0, ovf_count 2, locked 1.
REQ-034 Beats 1,1,2,4 then 6 -> error high one cycle after beat 4, err_count 1, locked 0; after beat 6 (2+4) locked 1, err_count still 1.
REQ-035 17 valid beats values 1..17 -> wrapped 1, seq_len 17; rd_addr 0 -> rd_data 17 next cycle, rd_addr 1 -> 2.
REQ-036 rst high mid-stream with in_valid high -> all outputs per REQ-030 next cycle; following beats 5,5 seed with no error, then 10 matches.
REQ-037 Beats separated by 1-3 idle cycles (in_valid low) -> results identical to back-to-back; 256+ mismatching beats -> err_count holds 255.
